// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state type and parity helper
// Purpose: common definitions for the UART transmit and receive buffers.
// Ports: none (package).
package uart_pkg;

    localparam int   DEF_DATA_BIT = 8;
    localparam int   FRAME_W      = DEF_DATA_BIT + 3;
    localparam logic START_BIT    = 1'b0;
    localparam logic STOP_BIT     = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    // Zero-extension leaves the XOR reduction unchanged, so any payload up to
    // 32 bits can be passed in through a width cast.
    function automatic logic odd_parity(input logic [31:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/uart_tx_buf_if.sv
// rtl/uart_tx_buf_if.sv - valid/ready byte push interface
// Purpose: groups the push handshake into the transmit buffer.
// Ports: tx_data (byte), tx_valid (push request), tx_ready (space available).
interface uart_tx_buf_if #(
    parameter int DATA_BIT = 8
);
    logic [DATA_BIT-1:0] tx_data;
    logic                tx_valid;
    logic                tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO for the UART buffers
// Purpose: DEPTH-entry FIFO, same-edge push/pop, pointers wrap modulo DEPTH.
// Ports: clk, rst_n (async active-low), push_i/wr_data_i, pop_i/rd_data_o
//        (head, valid when not empty), full_o, empty_o, count_o.
module uart_fifo #(
    parameter int DATA_BIT = 8,
    parameter int DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [DATA_BIT-1:0]        wr_data_i,
    input  logic                       pop_i,
    output logic [DATA_BIT-1:0]        rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_BIT-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         count_q;
    logic                do_push, do_pop;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Requests are masked here so callers never corrupt the pointers.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - buffered UART transmitter (start, data LSB first, odd parity, stop)
// Purpose: queues pushed bytes and serialises them at clkdiv+1 clk cycles per bit.
// Ports: clk, rst_n (async active-low), clkdiv (bit period minus one),
//        push_if (tx_data/tx_valid/tx_ready), tx (serial line, idle high),
//        busy (frame on the line), empty, count (FIFO occupancy).
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int DATA_BIT = DEF_DATA_BIT,
    parameter int DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            clkdiv,
    uart_tx_buf_if.slave           push_if,
    output logic                   tx,
    output logic                   busy,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int FRAME_LEN = DATA_BIT + 3;
    localparam int BW        = $clog2(FRAME_LEN + 1);

    tx_state_t              state_q, state_d;
    logic [FRAME_LEN-1:0]   shift_q, shift_d;
    logic [15:0]            cyc_q, cyc_d;
    logic [15:0]            div_q, div_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;

    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_BIT-1:0]    head;

    uart_fifo #(
        .DATA_BIT (DATA_BIT),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push_if.tx_valid),
        .wr_data_i (push_if.tx_data),
        .pop_i     (pop),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (count)
    );

    assign push_if.tx_ready = !fifo_full;
    assign empty            = fifo_empty;
    assign tx               = tx_q;
    assign busy             = busy_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cyc_d   = cyc_q;
        div_d   = div_q;
        bit_d   = bit_q;
        pop     = 1'b0;
        // The line and busy flag are registered copies of the state, so the
        // frame appears one cycle after load and busy covers exactly the frame.
        tx_d    = (state_q == SEND) ? shift_q[0] : 1'b1;
        busy_d  = (state_q == SEND);

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = {STOP_BIT, odd_parity(32'(head)), head, START_BIT};
                    cyc_d   = '0;
                    bit_d   = '0;
                    div_d   = clkdiv;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (cyc_q == div_q) begin
                    cyc_d   = '0;
                    shift_d = {1'b1, shift_q[FRAME_LEN-1:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == BW'(FRAME_LEN - 1)) begin
                        state_d = IDLE;
                    end
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '1;
            cyc_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cyc_q   <= cyc_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb/tb_uart_tx_buf.sv - self-checking bench for uart_tx_buf
module tb_uart_tx_buf;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] clkdiv;
    logic        tx;
    logic        busy;
    logic        empty;
    logic [2:0]  count;

    uart_tx_buf_if #(.DATA_BIT(8)) push_if ();

    uart_tx_buf #(
        .DATA_BIT (8),
        .DEPTH    (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clkdiv  (clkdiv),
        .push_if (push_if),
        .tx      (tx),
        .busy    (busy),
        .empty   (empty),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: byte queue for the FIFO, and for the frame being sent
    // its 11 bits, its bit period and the cycles of state left.
    logic [7:0]  m_fifo [$];
    logic [10:0] m_frame;
    int          m_div;
    int          m_timer;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, ((ones % 2) == 0), b, 1'b0};
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_timer = 0;
        m_div   = 0;
        m_frame = '1;
    endtask

    // One clock cycle: drive at the negedge, advance the model on the
    // posedge, compare all outputs on the following negedge.
    task automatic tick(input logic v, input logic [7:0] d);
        int   pre, idx;
        logic e_tx, e_busy, do_pop, do_push;
        push_if.tx_valid = v;
        push_if.tx_data  = d;
        @(posedge clk);
        pre = m_timer;
        if (pre > 0) begin
            idx    = (11 * (m_div + 1) - pre) / (m_div + 1);
            e_tx   = m_frame[idx];
            e_busy = 1'b1;
        end else begin
            e_tx   = 1'b1;
            e_busy = 1'b0;
        end
        do_pop  = (pre == 0) && (m_fifo.size() > 0);
        do_push = v && (m_fifo.size() < DEPTH);
        if (do_pop) begin
            m_frame = make_frame(m_fifo.pop_front());
            m_div   = int'(clkdiv);
            m_timer = 11 * (m_div + 1);
        end else if (pre > 0) begin
            m_timer = pre - 1;
        end
        if (do_push) m_fifo.push_back(d);
        @(negedge clk);
        check_eq("tx",    32'(tx),    32'(e_tx));
        check_eq("busy",  32'(busy),  32'(e_busy));
        check_eq("count", 32'(count), 32'(m_fifo.size()));
        check_eq("empty", 32'(empty), 32'(m_fifo.size() == 0));
        check_eq("ready", 32'(push_if.tx_ready), 32'(m_fifo.size() < DEPTH));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_tx"},    32'(tx),    32'd1);
        check_eq({tag, "_busy"},  32'(busy),  32'd0);
        check_eq({tag, "_count"}, 32'(count), 32'd0);
        check_eq({tag, "_empty"}, 32'(empty), 32'd1);
        check_eq({tag, "_ready"}, 32'(push_if.tx_ready), 32'd1);
    endtask

    initial begin
        rst_n            = 1'b0;
        clkdiv           = 16'd15;
        push_if.tx_valid = 1'b0;
        push_if.tx_data  = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        idle(3);

        // Single byte at 16 cycles per bit.
        tick(1'b1, 8'hA5);
        idle(200);

        // Parity corner bytes, queued back to back.
        tick(1'b1, 8'h01);
        tick(1'b1, 8'hFF);
        tick(1'b1, 8'h00);
        idle(3 * 180);

        // FIFO fill and overflow at 4 cycles per bit; 0x66 is dropped.
        clkdiv = 16'd3;
        tick(1'b1, 8'h11);
        tick(1'b1, 8'h22);
        tick(1'b1, 8'h33);
        tick(1'b1, 8'h44);
        tick(1'b1, 8'h55);
        check_eq("peak_count", 32'(count), 32'd4);
        tick(1'b1, 8'h66);
        idle(5 * 45 + 20);

        // Push on the edge the FSM pops with one entry held.
        tick(1'b1, 8'h3C);
        tick(1'b1, 8'hC3);
        idle(100);

        // Reset during data bit 3 of 0x5A with another byte queued.
        tick(1'b1, 8'h5A);
        tick(1'b1, 8'h77);
        idle(17);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(60);

        // clkdiv change during bit 2 applies only to the next frame.
        clkdiv = 16'd7;
        tick(1'b1, 8'hC6);
        idle(18);
        clkdiv = 16'd3;
        tick(1'b1, 8'h39);
        idle(150);

        // Randomised traffic with occasional clkdiv changes.
        for (int i = 0; i < 3000; i++) begin
            if ((i % 500) == 0) clkdiv = 16'($urandom_range(0, 4));
            tick(($urandom_range(0, 3) == 0), 8'($urandom));
        end
        idle(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
